// File: rtl/game_button_ctrl.sv
// game_button_ctrl: conditions the three raw active-low board push-buttons
// (start, pause, reset) into debounced levels and registered single-cycle
// command pulses for the game state machine. Simultaneous presses are
// resolved reset > pause > start, and a lockout window after each command
// discards further press events.
module game_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int LOCKOUT_CYCLES  = 0,
  parameter int LOCK_W          = 8
) (
  input  logic       clk,
  input  logic       resetFSM,
  input  logic       btn_start_n,
  input  logic       btn_pause_n,
  input  logic       btn_reset_n,
  output logic       startGame,
  output logic       pauseGame,
  output logic       reset,
  output logic [2:0] pressed
);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);

  // Button vectors are ordered {reset, pause, start} throughout.
  logic [2:0]       rawN;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       s;
  logic [2:0]       level;
  logic [2:0]       levelDly;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       pressEvt;
  logic [2:0]       cmd;
  logic [2:0]       cmdNext;
  logic [LOCK_W-1:0] lockCnt;

  assign rawN = {btn_reset_n, btn_pause_n, btn_start_n};
  assign s    = ~sync2;

  // Two-flop synchroniser; resets to the released (high) level so a held
  // button is seen as a fresh press after reset.
  always_ff @(posedge clk) begin
    if (resetFSM) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= rawN;
      sync2 <= sync1;
    end
  end

  // Counter debounce: the level only follows s after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement clears the count.
  always_ff @(posedge clk) begin
    if (resetFSM) begin
      level    <= 3'b000;
      levelDly <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      levelDly <= level;
      for (int i = 0; i < 3; i++) begin
        if (s[i] != level[i]) begin
          if (cnt[i] == CNT_LAST) begin
            level[i] <= s[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign pressEvt = level & ~levelDly;

  // Fixed-priority arbitration of press events; losers and events arriving
  // during lockout are simply dropped.
  always_comb begin
    cmdNext = 3'b000;
    if (lockCnt == '0) begin
      if (pressEvt[2]) begin
        cmdNext = 3'b100;
      end else if (pressEvt[1]) begin
        cmdNext = 3'b010;
      end else if (pressEvt[0]) begin
        cmdNext = 3'b001;
      end
    end
  end

  // Registered command pulses and the lockout counter, which reloads on
  // every emitted command and otherwise counts down to zero and stays there.
  always_ff @(posedge clk) begin
    if (resetFSM) begin
      cmd     <= 3'b000;
      lockCnt <= '0;
    end else begin
      cmd <= cmdNext;
      if (cmdNext != 3'b000) begin
        lockCnt <= LOCK_LOAD;
      end else if (lockCnt != '0) begin
        lockCnt <= lockCnt - LOCK_W'(1);
      end
    end
  end

  assign startGame = cmd[0];
  assign pauseGame = cmd[1];
  assign reset     = cmd[2];
  assign pressed   = level;

endmodule
